fpadd_ctrl: RTL and testbench

FPADD_CTRL -- requirements
Module: fpadd_ctrl

---
 rtl/fpadd_ctrl.sv | 109 ++++++++++
 tb/tb_fpadd_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_ctrl.sv
// Sequencer between an operand stream, a multi-cycle FP adder and a result consumer.
// Define FPADD_CTRL_TIMEOUT_EN to bound the wait for add_done by TIMEOUT_CYCLES.
module fpadd_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        add_start,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    input  logic        add_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state;

    // Both ports use valid/ready: a beat moves on the rising edge where valid && ready,
    // and the sender keeps its payload stable until then.
    assign in_ready  = (state == IDLE);
    assign state_dbg = state;

`ifdef FPADD_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_inc;

    always_comb begin
        wait_cnt_inc = (wait_cnt == CW'(TIMEOUT_CYCLES)) ? wait_cnt : wait_cnt + CW'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            add_start <= 1'b0;
            add_a     <= 32'd0;
            add_b     <= 32'd0;
            out_valid <= 1'b0;
            out_sum   <= 32'd0;
            out_err   <= 1'b0;
`ifdef FPADD_CTRL_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        add_a     <= in_a;
                        add_b     <= in_b;
                        add_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    add_start <= 1'b0;
                    state     <= WAIT;
`ifdef FPADD_CTRL_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end
                // add_done is only trusted here; a done left over from the
                // previous operation is cleared by the adder on add_start.
                WAIT: begin
                    if (add_done) begin
                        out_sum   <= add_sum;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
`ifdef FPADD_CTRL_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt_inc;
                        if (wait_cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                            out_sum   <= 32'h7FC0_0000;
                            out_err   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
`endif
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpadd_ctrl.sv
// Self-checking bench for fpadd_ctrl: behavioural adder with programmable latency,
// table-driven vectors, randomized transactions and multi-cycle corner sequences.
module tb_fpadd_ctrl;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        in_ready;
    logic        add_start;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum = 32'd0;
    logic        add_done = 1'b0;
    logic        out_valid;
    logic [31:0] out_sum;
    logic        out_err;
    logic [1:0]  state_dbg;

    fpadd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_done(add_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_err(out_err), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters and check ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [63:0] s2d(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:0] == 31'd0) return {s[31], 63'd0};
        e = {3'b000, s[30:23]} + 11'd896;
        return {s[31], e, s[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2s(input logic [63:0] d);
        logic [10:0] e;
        e = d[62:52];
        if (e == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return d2s($realtobits($bitstoreal(s2d(a)) + $bitstoreal(s2d(b))));
    endfunction

    // Adder latency l (0 = never completes) -> does the controller give up first?
    function automatic bit timed_out(input int l);
`ifdef FPADD_CTRL_TIMEOUT_EN
        return (l == 0) || (l + 2 > TO + 1);
`else
        return (l < 0);
`endif
    endfunction

    function automatic int exp_cycles(input int l);
        return timed_out(l) ? TO + 1 : l + 2;
    endfunction

    function automatic logic [32:0] ref_result(input logic [31:0] a, input logic [31:0] b, input int l);
        return timed_out(l) ? {1'b1, 32'h7FC0_0000} : {1'b0, fp_add(a, b)};
    endfunction

    // ---------------- behavioural adder ----------------
    int lat = 5;
    int rem = 0;

    always @(posedge clk) begin
        if (add_start) begin
            rem      <= lat;
            add_done <= 1'b0;
            add_sum  <= fp_add(add_a, add_b);
        end else if (rem != 0) begin
            rem <= rem - 1;
            if (rem == 1) add_done <= 1'b1;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [32:0] exp_q[$];
    logic [31:0] cur_a, cur_b;
    bit          busy = 1'b0;
    bit          prev_start = 1'b0;
    int          start_cnt = 0;
    int          res_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            busy       = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (busy) begin
                check("operand_a_stable", add_a, cur_a);
                check("operand_b_stable", add_b, cur_b);
            end
            if (add_start) begin
                start_cnt++;
                check("start_one_cycle", prev_start, 1'b0);
            end
            prev_start = add_start;
            if (out_valid && out_ready) begin
                res_cnt++;
                check("result_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("sb_sum", out_sum, e[31:0]);
                    check("sb_err", out_err, e[32]);
                end
                busy = 1'b0;
            end
            if (in_valid && in_ready) begin
                busy  = 1'b1;
                cur_a = in_a;
                cur_b = in_b;
                if (timed_out(lat) || lat != 0) exp_q.push_back(ref_result(in_a, in_b, lat));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_add_start"}, add_start, 1'b0);
        check({tag, "_out_sum"}, out_sum, 32'd0);
        check({tag, "_out_err"}, out_err, 1'b0);
        check({tag, "_add_a"}, add_a, 32'd0);
        check({tag, "_add_b"}, add_b, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit keep);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("send_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input int l,
                           input int stall, input logic [31:0] done_sum);
        int cyc;
        int s0;
        logic [32:0] e;
        lat = l;
        s0  = start_cnt;
        e   = timed_out(l) ? {1'b1, 32'h7FC0_0000} : {1'b0, done_sum};
        send(a, b, 1'b0);
        cyc = 0;
        while (cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) break;
        end
        check("latency", cyc, exp_cycles(l));
        check("out_sum", out_sum, e[31:0]);
        check("out_err", out_err, e[32]);
        check("start_pulses", start_cnt - s0, 1);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", out_valid, 1'b1);
            check("stall_sum", out_sum, e[31:0]);
            check("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("release_valid", out_valid, 1'b0);
        check("release_in_ready", in_ready, 1'b1);
    endtask

    // ---------------- test sequence ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          l;
        int          stall;
        logic [31:0] sum;
    } vec_t;

    vec_t vt[6];

    initial begin
        int s0;
        int r0;
        int seen;
        logic [31:0] ra, rb;

        vt[0] = '{32'h3F80_0000, 32'h4000_0000, 5,  0,  32'h4040_0000};
        vt[1] = '{32'h40A0_0000, 32'h3F00_0000, 4,  10, 32'h40B0_0000};
        vt[2] = '{32'hBF80_0000, 32'h4000_0000, 2,  1,  32'h3F80_0000};
        vt[3] = '{32'h4040_0000, 32'h4040_0000, 1,  0,  32'h40C0_0000};
        vt[4] = '{32'h3F80_0000, 32'h3F80_0000, 63, 0,  32'h4000_0000};
        vt[5] = '{32'h4000_0000, 32'h4000_0000, 64, 2,  32'h4080_0000};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state("reset");

        foreach (vt[i]) run_one(vt[i].a, vt[i].b, vt[i].l, vt[i].stall, vt[i].sum);

        for (int i = 0; i < 16; i++) begin
            ra = {1'($urandom_range(1, 0)), 8'($urandom_range(140, 110)), 23'($urandom)};
            rb = {1'($urandom_range(1, 0)), 8'($urandom_range(140, 110)), 23'($urandom)};
            run_one(ra, rb, $urandom_range(12, 1), $urandom_range(3, 0), fp_add(ra, rb));
        end

        // Back-to-back with in_valid held high and a stale done present in START.
        lat = 3;
        out_ready = 1'b1;
        s0 = start_cnt;
        r0 = res_cnt;
        for (int i = 0; i < 4; i++) begin
            send(32'h3F80_0000 + 32'(i << 20), 32'h4000_0000 + 32'(i << 19), i < 3);
        end
        seen = 0;
        while (res_cnt - r0 < 4 && seen < 200) begin
            @(posedge clk);
            #1 seen++;
        end
        check("b2b_results", res_cnt - r0, 4);
        check("b2b_starts", start_cnt - s0, 4);
        check("b2b_queue_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1 check("b2b_no_extra", res_cnt - r0, 4);
        out_ready = 1'b0;

        // Reset in the middle of WAIT; the adder's done lands two cycles later.
        lat = 5;
        send(32'h4000_0000, 32'h4000_0000, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state("midwait_reset");
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) seen++;
        end
        check("late_done_ignored", seen, 0);
        check("late_done_present", add_done, 1'b1);

`ifdef FPADD_CTRL_TIMEOUT_EN
        run_one(32'h3F80_0000, 32'h3F80_0000, 0, 3, 32'h0);
`else
        lat = 0;
        send(32'h3F80_0000, 32'h3F80_0000, 1'b0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("no_timeout_valid", seen, 0);
        do_reset();
        check_reset_state("final_reset");
`endif

        // Recovery: a normal operation still works afterwards.
        run_one(32'h3F80_0000, 32'h4000_0000, 5, 0, 32'h4040_0000);
        repeat (4) @(posedge clk);
        #1 check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
